cnnip_mem_master: RTL and testbench
===================================

// Module: cnnip_mem_master
// PURPOSE
//  Initiator end of the cnnip_mem_if word-access protocol (en/we/addr/din/dout/valid). Turns one burst
//  command (base byte address, word count, read/write) into single-word accesses to a memory slave.
//  Streams read words out through a ready/valid FIFO and accepts write words through a ready/valid input.
//  Sits between CNN IP datapath engines (DMA/loader) and one port of the dual-port block RAM wrapper.
// PARAMETERS
//  ADDR_WIDTH     12  byte-address width of mem_addr; word stride 4, wraps modulo 2^ADDR_WIDTH
//  LEN_WIDTH      11  width of cmd_len (words per command)
//  RD_FIFO_DEPTH  4   read-data FIFO entries (power of 2, >=2), each {last, data[31:0]}
//  TIMEOUT_CYCLES 15  max cycles from read en to mem_valid before abort (>= slave read latency)
// PORTS
//  clk_a       in   1           clock
//  arst_aq     in   1           reset. One clock; reset is asynchronous and active-high.
//  cmd_valid   in   1           command offered
//  cmd_ready   out  1           command accepted when cmd_valid&cmd_ready
//  cmd_write   in   1           1=write burst, 0=read burst
//  cmd_addr    in   ADDR_WIDTH  base byte address; bits [1:0] ignored (forced 0)
//  cmd_len     in   LEN_WIDTH   number of 32-bit words; 0 = empty command
//  wr_valid    in   1           write word offered
//  wr_ready    out  1           write word accepted when wr_valid&wr_ready
//  wr_data     in   32          write word
//  rd_valid    out  1           FIFO head valid
//  rd_ready    in   1           consumer pops head when rd_valid&rd_ready
//  rd_data     out  32          FIFO head data
//  rd_last     out  1           head is final word of its command
//  mem_en      out  1           memory enable (one-cycle pulse per access)
//  mem_we      out  1           memory write enable
//  mem_addr    out  ADDR_WIDTH  memory byte address
//  mem_din     out  32          memory write data
//  mem_dout    in   32          memory read data, sampled only when mem_valid=1
//  mem_valid   in   1           slave read-data strobe (one cycle)
//  busy        out  1           state != IDLE
//  done        out  1           one-cycle pulse at command completion
//  err_timeout out  1           sticky; cleared when next command is accepted
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, all outputs 0 except cmd_ready=1; counters/address cleared. Reset
//   mid-burst aborts immediately; no done pulse; buffered read words are discarded.
//  FSM IDLE/RD_ISSUE/RD_WAIT/WR/DONE. At most one read outstanding.
//  IDLE: cmd_ready=1. Accept with len!=0: latch addr (bits[1:0]=0), remaining=len, clear err_timeout,
//   go to RD_ISSUE or WR. Accept with len==0: next cycle is DONE (done pulse), then IDLE; no mem access.
//  RD_ISSUE: if FIFO count<RD_FIFO_DEPTH: mem_en=1, mem_we=0 for exactly this cycle -> RD_WAIT;
//   else stall with mem_en=0.
//  RD_WAIT: mem_en=0; mem_addr held stable (slave re-samples it while waiting). On mem_valid: push
//   {remaining==1, mem_dout}; addr+=4; remaining-=1; go to DONE if last, else RD_ISSUE.
//   Cadence is one word per L+1 cycles for slave latency L. This guarantees the slave is back in its
//   idle state before the next en.
//  Timeout: wait counter reaches TIMEOUT_CYCLES in RD_WAIT without mem_valid -> set err_timeout,
//   drop remaining words, go to DONE. mem_valid outside RD_WAIT is ignored.
//  WR: wr_ready=1. On wr_valid: mem_en=1, mem_we=1, mem_din=wr_data in that same cycle; addr+=4;
//   remaining-=1; last word -> DONE. Back-to-back writes run one per cycle; no valid is expected.
//  DONE: done=1 for one cycle -> IDLE. For reads, done fires when the last word is pushed, not popped.
//  mem_we=0 whenever mem_en=0. Address wraps 0x..FFC -> 0x000 without error.
//  FIFO: pop on rd_valid&rd_ready. Same-cycle push and pop keep the count unchanged. rd_* are
//   registered FIFO head outputs. FIFO keeps draining in IDLE/DONE and during the next command.
// TESTING (DUT paired with blk_mem_wrapper, READ_LATENCY=3, memory preloaded)
//  Write cmd addr=0x010 len=4, data A0..A3 with wr_valid held -> 4 consecutive en&we cycles,
//   addr 0x010..0x01C, done 1 cycle after last write.
//  Read back addr=0x010 len=4, rd_ready=1 -> rd_data A0..A3, rd_last only on A3. en pulses 4 cycles apart
//   (valid 3 cycles after each en); done after 4th push.
//  Read len=6 with rd_ready=0 -> exactly 4 reads issued then stall; raise rd_ready -> remaining 2 issued,
//   6 words in order.
//  Read addr=0xFF8 len=3 -> mem_addr 0xFF8, 0xFFC, 0x000; no error.
//  Slave model never asserts mem_valid -> err_timeout=1 after 15 wait cycles; done pulse, no FIFO push;
//   next cmd clears err.
//  cmd_len=0 -> no mem_en; done 1 cycle after accept. Assert arst_aq mid-read -> all outputs reset,
//   FIFO empty.

Source files
------------

// File: rtl/cnnip_mem_master.sv
// cnnip_mem_master: initiator of the cnnip_mem_if word protocol. Splits one burst command
//   (base byte address, word count, read/write) into single-word en/we accesses to a memory slave.
// Latency: one cycle from command accept to the first access; writes run one per cycle; reads run
//   one per L+1 cycles for slave latency L; done pulses the cycle after the last write or read push.
// Backpressure: cmd_ready only in IDLE; writes wait on wr_valid; read issue stalls while the read
//   FIFO is full; the FIFO drains on rd_valid&rd_ready in any state.
// Ports: clk_a/arst_aq clock and async active-high reset; cmd_* burst command (valid/ready);
//   wr_* write words in (valid/ready); rd_* read words out of the FIFO (valid/ready, rd_last
//   tags the final word of a command); mem_* single-word slave port; busy/done/err_timeout status.
module cnnip_mem_master #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned LEN_WIDTH      = 11,
  parameter int unsigned RD_FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_a,
  input  logic                  arst_aq,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_data,
  output logic                  rd_last,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } rd_entry_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  err_q, err_d;
  logic [TO_W-1:0]       wait_q, wait_d;

  rd_entry_t             fifo_q [RD_FIFO_DEPTH];
  rd_entry_t             fifo_d [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  push;
  logic                  pop;
  rd_entry_t             push_entry;
  rd_entry_t             head;

  // The slave only ever sees word-aligned addresses; the low bits are dropped.
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  // ---------------------------------------------------------------------------
  // Control FSM: next state, datapath updates and per-cycle outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    err_d      = err_q;
    wait_d     = wait_q;
    push       = 1'b0;
    push_entry = '0;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_din    = '0;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // A new command always starts with a clean error flag.
          err_d  = 1'b0;
          addr_d = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          rem_d  = cmd_len;
          if (cmd_len == '0) begin
            state_d = ST_DONE;
          end else if (cmd_write) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_RD_ISSUE: begin
        // Only issue when the returning word is guaranteed a FIFO slot.
        if (cnt_q < CNT_W'(RD_FIFO_DEPTH)) begin
          mem_en  = 1'b1;
          wait_d  = '0;
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // mem_addr stays on addr_q: the slave may re-sample it while it works.
        if (mem_valid) begin
          push            = 1'b1;
          push_entry.last = (rem_q == LEN_WIDTH'(1));
          push_entry.data = mem_dout;
          addr_d          = addr_q + ADDR_WIDTH'(4);
          rem_d           = rem_q - LEN_WIDTH'(1);
          state_d         = (rem_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD_ISSUE;
        end else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last wait cycle the slave is allowed; abandon the burst.
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end

      ST_WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          mem_din = wr_data;
          addr_d  = addr_q + ADDR_WIDTH'(4);
          rem_d   = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-data FIFO (circular buffer, power-of-two depth so pointers wrap freely)
  // ---------------------------------------------------------------------------
  assign rd_valid = (cnt_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign head     = fifo_q[rd_ptr_q];
  assign rd_data  = rd_valid ? head.data : '0;
  assign rd_last  = rd_valid & head.last;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_a or posedge arst_aq) begin
    if (arst_aq) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fifo_q   <= fifo_d;
    end
  end

  assign mem_addr    = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_cnnip_mem_master.sv
// tb_cnnip_mem_master: bench for cnnip_mem_master with a latency-programmable memory slave.
// Latency: n/a (testbench).
// Backpressure: rd_ready and wr_valid are driven by programmable producer/consumer processes.
module tb_cnnip_mem_master;

  logic        clk_a = 1'b0;
  logic        arst_aq;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [10:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        mem_en, mem_we, mem_valid;
  logic [11:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        busy, done, err_timeout;

  always #5 clk_a = ~clk_a;

  cnnip_mem_master #(
    .ADDR_WIDTH(12), .LEN_WIDTH(11), .RD_FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk_a(clk_a), .arst_aq(arst_aq),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_valid(mem_valid),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Memory contents: slv_mem is what the slave holds, ref_mem what the model says it should hold.
  logic [31:0] slv_mem [1024];
  logic [31:0] ref_mem [1024];

  int          slv_lat  = 3;
  bit          slv_mute = 1'b0;
  int          slv_cnt  = 0;
  logic [11:0] slv_addr = '0;

  typedef struct { bit we; logic [11:0] addr; logic [31:0] din; int cyc; } acc_t;
  typedef struct { logic [31:0] d; bit last; } pop_t;
  acc_t acc_q[$];
  pop_t pop_q[$];
  int   done_cnt   = 0;
  int   done_cyc   = 0;
  int   accept_cyc = 0;
  int   wr_hs      = 0;
  int   cyc        = 0;
  bit   prev_err   = 1'b0;

  int          rd_mode = 1;    // 0: never ready, 1: always ready, 2: random
  bit          wr_hold = 1'b1; // 1: wr_valid held while words remain, 0: random gaps
  logic [31:0] wr_words[$];

  always @(posedge clk_a) cyc <= cyc + 1;

  // Slave + bus monitor, evaluated mid-cycle when all DUT outputs are settled.
  initial begin
    mem_valid = 1'b0;
    mem_dout  = '0;
    forever begin
      @(negedge clk_a);
      if (arst_aq) begin
        slv_cnt   = 0;
        mem_valid = 1'b0;
        mem_dout  = '0;
      end else begin
        if (!mem_en) check("we_without_en", mem_we, 1'b0);
        if (mem_en) acc_q.push_back('{mem_we, mem_addr, mem_din, cyc});
        if (mem_en && mem_we) slv_mem[mem_addr[11:2]] = mem_din;
        if (rd_valid && rd_ready) pop_q.push_back('{rd_data, rd_last});
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (wr_valid && wr_ready) wr_hs++;
        if (cmd_valid && cmd_ready) accept_cyc = cyc;
        mem_valid = 1'b0;
        if (slv_cnt > 0) begin
          slv_cnt--;
          if (slv_cnt == 0) begin
            mem_valid = 1'b1;
            mem_dout  = slv_mem[slv_addr[11:2]];
          end
        end
        if (mem_en && !mem_we && !slv_mute) begin
          slv_cnt  = slv_lat;
          slv_addr = mem_addr;
        end
      end
    end
  end

  // Read consumer and write producer.
  initial begin
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(posedge clk_a);
      #1;
      case (rd_mode)
        0:       rd_ready = 1'b0;
        1:       rd_ready = 1'b1;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (wr_hs < wr_words.size()) begin
        wr_valid = wr_hold ? 1'b1 : 1'($urandom_range(0, 1));
        wr_data  = wr_words[wr_hs];
      end else begin
        wr_valid = 1'b0;
        wr_data  = '0;
      end
    end
  end

  typedef struct {
    bit wr; logic [11:0] addr; int len; int lat; bit mute; int rdmode; bit hold;
    int exp_acc; logic [11:0] exp_last; bit exp_err; int exp_dly;
  } vec_t;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err_timeout, 1'b0);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 12'h000);
    check({tag, "_mem_din"}, mem_din, 32'h0);
    check({tag, "_wr_ready"}, wr_ready, 1'b0);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data, 32'h0);
    check({tag, "_rd_last"}, rd_last, 1'b0);
  endtask

  task automatic wait_done_and_pops(input string tag, input int n_pop);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin @(negedge clk_a); k++; end
    if (k >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_done_wait: no done pulse within 3000 cycles, required one", tag);
    end
    k = 0;
    while (pop_q.size() < n_pop && k < 3000) begin @(negedge clk_a); k++; end
    if (k >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_pop_wait: got %0d words, required %0d", tag, pop_q.size(), n_pop);
    end
    repeat (3) @(negedge clk_a);
  endtask

  // Runs one command and checks it against the burst rules; table rows add constant expectations.
  task automatic run_cmd(input vec_t v, input bit use_const);
    logic [11:0] base, ea;
    int          n_acc, n_pop, exp_dly, dly;
    bit          exp_err;
    base    = {v.addr[11:2], 2'b00};
    exp_err = !v.wr && v.mute && (v.len > 0);
    n_acc   = (v.len == 0) ? 0 : (exp_err ? 1 : v.len);
    n_pop   = (!v.wr && !exp_err) ? v.len : 0;
    exp_dly = (n_acc == 0 || v.wr) ? 1 : (exp_err ? 16 : v.lat + 1);

    @(posedge clk_a); #2;
    slv_lat = v.lat; slv_mute = v.mute; rd_mode = v.rdmode; wr_hold = v.hold;
    acc_q.delete(); pop_q.delete(); done_cnt = 0; wr_hs = 0; wr_words.delete();
    if (v.wr) for (int i = 0; i < v.len; i++) wr_words.push_back($urandom);
    check("err_before_cmd", err_timeout, prev_err);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = 11'(v.len);
    @(negedge clk_a);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk_a); #2;
    cmd_valid = 1'b0;
    @(negedge clk_a);
    check("busy_after_accept", busy, 1'b1);
    if (v.len != 0) check("err_cleared_on_accept", err_timeout, 1'b0);
    wait_done_and_pops("cmd", n_pop);

    check("done_pulses", done_cnt, 1);
    check("access_count", acc_q.size(), n_acc);
    for (int i = 0; i < acc_q.size() && i < n_acc; i++) begin
      ea = base + 12'(4 * i);
      check("access_addr", acc_q[i].addr, ea);
      check("access_we", acc_q[i].we, v.wr);
      if (v.wr) check("access_din", acc_q[i].din, wr_words[i]);
      if (!v.wr && v.rdmode == 1 && i > 0)
        check("read_cadence", acc_q[i].cyc - acc_q[i-1].cyc, v.lat + 1);
    end
    dly = (acc_q.size() > 0) ? done_cyc - acc_q[acc_q.size()-1].cyc : done_cyc - accept_cyc;
    check("done_delay", dly, exp_dly);
    check("err_after_cmd", err_timeout, exp_err);
    check("pop_count", pop_q.size(), n_pop);
    for (int i = 0; i < pop_q.size() && i < n_pop; i++) begin
      ea = base + 12'(4 * i);
      check("rd_data", pop_q[i].d, ref_mem[ea[11:2]]);
      check("rd_last", pop_q[i].last, (i == n_pop - 1));
    end
    check("fifo_drained", rd_valid, 1'b0);
    if (use_const) begin
      check("tbl_access_count", acc_q.size(), v.exp_acc);
      if (v.exp_acc > 0 && acc_q.size() > 0)
        check("tbl_last_addr", acc_q[acc_q.size()-1].addr, v.exp_last);
      check("tbl_err", err_timeout, v.exp_err);
      check("tbl_done_delay", dly, v.exp_dly);
    end
    if (v.wr) for (int i = 0; i < v.len; i++) begin
      ea = base + 12'(4 * i);
      ref_mem[ea[11:2]] = wr_words[i];
    end
    prev_err = exp_err;
    wr_words.delete();
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    //          wr    addr     len lat mute rdm hold  acc last     err dly
    tbl[0]  = '{1'b1, 12'h010, 4,  3,  1'b0, 1, 1'b1, 4, 12'h01C, 1'b0, 1};
    tbl[1]  = '{1'b0, 12'h010, 4,  3,  1'b0, 1, 1'b1, 4, 12'h01C, 1'b0, 4};
    tbl[2]  = '{1'b0, 12'hFF8, 3,  3,  1'b0, 1, 1'b1, 3, 12'h000, 1'b0, 4};
    tbl[3]  = '{1'b0, 12'h100, 5,  3,  1'b1, 1, 1'b1, 1, 12'h100, 1'b1, 16};
    tbl[4]  = '{1'b0, 12'h104, 2,  3,  1'b0, 1, 1'b1, 2, 12'h108, 1'b0, 4};
    tbl[5]  = '{1'b1, 12'h200, 0,  3,  1'b0, 1, 1'b1, 0, 12'h000, 1'b0, 1};
    tbl[6]  = '{1'b0, 12'h300, 0,  3,  1'b0, 1, 1'b1, 0, 12'h000, 1'b0, 1};
    tbl[7]  = '{1'b1, 12'hFFC, 3,  3,  1'b0, 1, 1'b0, 3, 12'h004, 1'b0, 1};
    tbl[8]  = '{1'b0, 12'hFFC, 3,  1,  1'b0, 2, 1'b1, 3, 12'h004, 1'b0, 2};
    tbl[9]  = '{1'b1, 12'h013, 2,  3,  1'b0, 1, 1'b1, 2, 12'h014, 1'b0, 1};
    tbl[10] = '{1'b0, 12'h012, 2,  2,  1'b0, 1, 1'b1, 2, 12'h014, 1'b0, 3};
    tbl[11] = '{1'b0, 12'h040, 9,  5,  1'b0, 2, 1'b1, 9, 12'h060, 1'b0, 6};
    tbl[12] = '{1'b0, 12'h010, 4, 15,  1'b0, 1, 1'b1, 4, 12'h01C, 1'b0, 16};

    arst_aq = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    for (int i = 0; i < 1024; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    repeat (3) @(posedge clk_a);
    @(negedge clk_a);
    check_reset_outputs("reset");
    @(posedge clk_a); #2;
    arst_aq = 1'b0;

    for (int i = 0; i < 13; i++) run_cmd(tbl[i], 1'b1);

    // Full FIFO stalls issue after four reads until the consumer drains it.
    @(posedge clk_a); #2;
    slv_lat = 3; slv_mute = 1'b0; rd_mode = 0;
    acc_q.delete(); pop_q.delete(); done_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_len = 11'd6;
    @(posedge clk_a); #2;
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk_a);
    check("stall_access_count", acc_q.size(), 4);
    check("stall_rd_valid", rd_valid, 1'b1);
    check("stall_busy", busy, 1'b1);
    check("stall_mem_en", mem_en, 1'b0);
    check("stall_no_done", done_cnt, 0);
    rd_mode = 1;
    wait_done_and_pops("stall", 6);
    check("stall_access_total", acc_q.size(), 6);
    check("stall_done_pulses", done_cnt, 1);
    check("stall_pop_count", pop_q.size(), 6);
    for (int i = 0; i < pop_q.size() && i < 6; i++) begin
      check("stall_rd_data", pop_q[i].d, ref_mem[8 + i]);
      check("stall_rd_last", pop_q[i].last, (i == 5));
    end
    prev_err = 1'b0;

    // Reset in the middle of a read burst with words buffered.
    @(posedge clk_a); #2;
    rd_mode = 0; acc_q.delete(); pop_q.delete(); done_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h080; cmd_len = 11'd8;
    @(posedge clk_a); #2;
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk_a);
    check("midrst_pre_rd_valid", rd_valid, 1'b1);
    check("midrst_pre_busy", busy, 1'b1);
    arst_aq = 1'b1;
    #1;
    check_reset_outputs("midrst");
    done_cnt = 0;
    repeat (2) @(posedge clk_a);
    #2;
    arst_aq = 1'b0;
    rd_mode = 1;
    repeat (4) @(negedge clk_a);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_fifo_empty", rd_valid, 1'b0);
    check("midrst_idle", cmd_ready, 1'b1);
    prev_err = 1'b0;

    // Random commands checked against the model.
    for (int n = 0; n < 40; n++) begin
      rv.wr     = 1'($urandom_range(0, 1));
      rv.addr   = 12'($urandom);
      rv.len    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      rv.lat    = int'($urandom_range(1, 6));
      rv.mute   = 1'b0;
      rv.rdmode = int'($urandom_range(1, 2));
      rv.hold   = 1'($urandom_range(0, 1));
      rv.exp_acc = 0; rv.exp_last = '0; rv.exp_err = 1'b0; rv.exp_dly = 0;
      run_cmd(rv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
